// File: rtl/sort_stats.sv
// ============================================================================
// sort_stats: per-packet min/max/sum/length/distinct/order statistics
// Rev 1.0
// ============================================================================
`default_nettype none

module sort_stats #(
    parameter  int DWIDTH      = 8,
    parameter  int MAX_PKT_LEN = 1024,
    localparam int LW          = $clog2(MAX_PKT_LEN) + 1,
    localparam int SW          = DWIDTH + LW - 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic              stat_valid_o,
    input  logic              stat_ready_i,
    output logic [DWIDTH-1:0] stat_min_o,
    output logic [DWIDTH-1:0] stat_max_o,
    output logic [SW-1:0]     stat_sum_o,
    output logic [LW-1:0]     stat_len_o,
    output logic [LW-1:0]     stat_uniq_o,
    output logic              stat_order_err_o,
    output logic              stat_frame_err_o
);

    localparam logic [LW-1:0] c_MAX_LEN = LW'(MAX_PKT_LEN);
    localparam logic [LW-1:0] c_ONE     = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RX     = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t              r_state;

    logic [DWIDTH-1:0]   r_min;
    logic [DWIDTH-1:0]   r_max;
    logic [DWIDTH-1:0]   r_prev;
    logic [SW-1:0]       r_sum;
    logic [LW-1:0]       r_len;
    logic [LW-1:0]       r_uniq;
    logic                r_oerr;
    logic                r_ferr;

    logic                r_stat_valid;
    logic [DWIDTH-1:0]   r_stat_min;
    logic [DWIDTH-1:0]   r_stat_max;
    logic [SW-1:0]       r_stat_sum;
    logic [LW-1:0]       r_stat_len;
    logic [LW-1:0]       r_stat_uniq;
    logic                r_stat_oerr;
    logic                r_stat_ferr;

    logic                w_accept;
    logic [DWIDTH-1:0]   w_min_n;
    logic [DWIDTH-1:0]   w_max_n;
    logic [DWIDTH-1:0]   w_prev_n;
    logic [SW-1:0]       w_sum_n;
    logic [LW-1:0]       w_len_n;
    logic [LW-1:0]       w_uniq_n;
    logic                w_oerr_n;
    logic                w_ferr_n;

    assign snk_ready_o = (r_state != S_RESULT);
    assign w_accept    = snk_valid_i && snk_ready_o;

    // Accumulator update for an accepted beat; only consumed in IDLE with sop, or in RX.
    always_comb begin
        w_min_n  = r_min;
        w_max_n  = r_max;
        w_prev_n = r_prev;
        w_sum_n  = r_sum;
        w_len_n  = r_len;
        w_uniq_n = r_uniq;
        w_oerr_n = r_oerr;
        w_ferr_n = r_ferr;
        if (snk_startofpacket_i) begin
            w_min_n  = snk_data_i;
            w_max_n  = snk_data_i;
            w_prev_n = snk_data_i;
            w_sum_n  = SW'(snk_data_i);
            w_len_n  = c_ONE;
            w_uniq_n = c_ONE;
            w_oerr_n = 1'b0;
            // A sop arriving mid-packet means the previous packet lost its eop.
            w_ferr_n = (r_state == S_RX);
        end else if (r_len < c_MAX_LEN) begin
            w_len_n  = r_len + c_ONE;
            w_sum_n  = r_sum + SW'(snk_data_i);
            if (snk_data_i < r_min) begin
                w_min_n = snk_data_i;
            end
            if (snk_data_i > r_max) begin
                w_max_n = snk_data_i;
            end
            if (snk_data_i != r_prev) begin
                w_uniq_n = r_uniq + c_ONE;
            end
            if (snk_data_i < r_prev) begin
                w_oerr_n = 1'b1;
            end
            w_prev_n = snk_data_i;
        end else begin
            w_ferr_n = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state      <= S_IDLE;
            r_min        <= '0;
            r_max        <= '0;
            r_prev       <= '0;
            r_sum        <= '0;
            r_len        <= '0;
            r_uniq       <= '0;
            r_oerr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_stat_valid <= 1'b0;
            r_stat_min   <= '0;
            r_stat_max   <= '0;
            r_stat_sum   <= '0;
            r_stat_len   <= '0;
            r_stat_uniq  <= '0;
            r_stat_oerr  <= 1'b0;
            r_stat_ferr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RX: begin
                    if (w_accept && (snk_startofpacket_i || (r_state == S_RX))) begin
                        r_min  <= w_min_n;
                        r_max  <= w_max_n;
                        r_prev <= w_prev_n;
                        r_sum  <= w_sum_n;
                        r_len  <= w_len_n;
                        r_uniq <= w_uniq_n;
                        r_oerr <= w_oerr_n;
                        r_ferr <= w_ferr_n;
                        if (snk_endofpacket_i) begin
                            r_state      <= S_RESULT;
                            r_stat_valid <= 1'b1;
                            r_stat_min   <= w_min_n;
                            r_stat_max   <= w_max_n;
                            r_stat_sum   <= w_sum_n;
                            r_stat_len   <= w_len_n;
                            r_stat_uniq  <= w_uniq_n;
                            r_stat_oerr  <= w_oerr_n;
                            r_stat_ferr  <= w_ferr_n;
                        end else begin
                            r_state <= S_RX;
                        end
                    end
                end
                S_RESULT: begin
                    if (stat_ready_i) begin
                        r_state      <= S_IDLE;
                        r_stat_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_stat_valid <= 1'b0;
                end
            endcase
        end
    end

    assign stat_valid_o     = r_stat_valid;
    assign stat_min_o       = r_stat_min;
    assign stat_max_o       = r_stat_max;
    assign stat_sum_o       = r_stat_sum;
    assign stat_len_o       = r_stat_len;
    assign stat_uniq_o      = r_stat_uniq;
    assign stat_order_err_o = r_stat_oerr;
    assign stat_frame_err_o = r_stat_ferr;

endmodule

`default_nettype wire

// File: tb/tb_sort_stats.sv
// ============================================================================
// tb_sort_stats: directed scoreboard bench for sort_stats (DWIDTH=8, MAX=16)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sort_stats;

    localparam int DW  = 8;
    localparam int MAX = 16;
    localparam int LW  = $clog2(MAX) + 1;
    localparam int SW  = DW + LW - 1;

    logic          clk_i = 1'b0;
    logic          srst_i;
    logic [DW-1:0] snk_data_i;
    logic          snk_startofpacket_i;
    logic          snk_endofpacket_i;
    logic          snk_valid_i;
    logic          snk_ready_o;
    logic          stat_valid_o;
    logic          stat_ready_i;
    logic [DW-1:0] stat_min_o;
    logic [DW-1:0] stat_max_o;
    logic [SW-1:0] stat_sum_o;
    logic [LW-1:0] stat_len_o;
    logic [LW-1:0] stat_uniq_o;
    logic          stat_order_err_o;
    logic          stat_frame_err_o;

    typedef struct packed {
        logic [31:0] mn;
        logic [31:0] mx;
        logic [31:0] sum;
        logic [31:0] len;
        logic [31:0] uniq;
        logic        oerr;
        logic        ferr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    sort_stats #(.DWIDTH(DW), .MAX_PKT_LEN(MAX)) dut (
        .clk_i               (clk_i),
        .srst_i              (srst_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .stat_valid_o        (stat_valid_o),
        .stat_ready_i        (stat_ready_i),
        .stat_min_o          (stat_min_o),
        .stat_max_o          (stat_max_o),
        .stat_sum_o          (stat_sum_o),
        .stat_len_o          (stat_len_o),
        .stat_uniq_o         (stat_uniq_o),
        .stat_order_err_o    (stat_order_err_o),
        .stat_frame_err_o    (stat_frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int mn, input int mx, input int sum, input int len,
                        input int uniq, input bit oerr, input bit ferr);
        exp_t e;
        e.mn = mn; e.mx = mx; e.sum = sum; e.len = len; e.uniq = uniq;
        e.oerr = oerr; e.ferr = ferr;
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic send_beat(input int d, input bit s, input bit e);
        int waitc;
        waitc = 0;
        snk_data_i          = DW'(d);
        snk_startofpacket_i = s;
        snk_endofpacket_i   = e;
        snk_valid_i         = 1'b1;
        while (!snk_ready_o && waitc < 50) begin
            @(posedge clk_i); #1;
            waitc++;
        end
        if (!snk_ready_o) begin
            n_checks++;
            $display("FAIL beat_accept_timeout: ready stayed %0d, expected 1", snk_ready_o);
        end
        @(posedge clk_i); #1;
        snk_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int waitc;
        waitc = 0;
        while (stat_valid_o && waitc < 50) begin
            @(posedge clk_i); #1;
            waitc++;
        end
        if (stat_valid_o) begin
            n_checks++;
            $display("FAIL drain_timeout: stat_valid %0d, expected 0", stat_valid_o);
        end
        @(posedge clk_i); #1;
    endtask

    // Monitor: every result handshake must match the oldest expected packet.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!srst_i && stat_valid_o && stat_ready_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_result: min=%0d max=%0d len=%0d, expected no result",
                             stat_min_o, stat_max_o, stat_len_o);
                end else begin
                    e = exp_q.pop_front();
                    if (32'(stat_min_o) == e.mn && 32'(stat_max_o) == e.mx &&
                        32'(stat_sum_o) == e.sum && 32'(stat_len_o) == e.len &&
                        32'(stat_uniq_o) == e.uniq && stat_order_err_o == e.oerr &&
                        stat_frame_err_o == e.ferr) begin
                        n_pass++;
                    end else begin
                        $display("FAIL result: got min=%0d max=%0d sum=%0d len=%0d uniq=%0d oerr=%0d ferr=%0d expected min=%0d max=%0d sum=%0d len=%0d uniq=%0d oerr=%0d ferr=%0d",
                                 stat_min_o, stat_max_o, stat_sum_o, stat_len_o, stat_uniq_o,
                                 stat_order_err_o, stat_frame_err_o,
                                 e.mn, e.mx, e.sum, e.len, e.uniq, e.oerr, e.ferr);
                    end
                end
            end
        end
    end

    initial begin
        srst_i              = 1'b1;
        snk_data_i          = '0;
        snk_startofpacket_i = 1'b0;
        snk_endofpacket_i   = 1'b0;
        snk_valid_i         = 1'b0;
        stat_ready_i        = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_ready", 32'(snk_ready_o), 1);
        chk("reset_valid", 32'(stat_valid_o), 0);
        chk("reset_sum", 32'(stat_sum_o), 0);
        chk("reset_len", 32'(stat_len_o), 0);
        srst_i = 1'b0;
        @(posedge clk_i); #1;

        // Stray beats with no sop must be dropped.
        send_beat(3, 0, 0);
        send_beat(4, 0, 1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("stray_no_result", 32'(stat_valid_o), 0);

        push(1, 9, 19, 5, 4, 0, 0);
        send_beat(1, 1, 0);
        send_beat(2, 0, 0);
        send_beat(2, 0, 0);
        send_beat(5, 0, 0);
        send_beat(9, 0, 1);
        chk("latency_valid", 32'(stat_valid_o), 1);
        chk("result_ready_low", 32'(snk_ready_o), 0);
        wait_drain();

        push(3, 8, 22, 4, 4, 1, 0);
        send_beat(3, 1, 0);
        send_beat(7, 0, 0);
        send_beat(4, 0, 0);
        send_beat(8, 0, 1);
        wait_drain();

        push(255, 255, 255, 1, 1, 0, 0);
        send_beat(255, 1, 1);
        chk("single_ready_low", 32'(snk_ready_o), 0);
        @(posedge clk_i); #1;
        chk("single_ready_back", 32'(snk_ready_o), 1);
        chk("single_valid_fall", 32'(stat_valid_o), 0);

        // Oversize: 20 beats, only the first 16 count.
        push(255, 255, 4080, 16, 1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            send_beat(255, i == 0, i == 19);
        end
        wait_drain();

        push(9, 10, 19, 2, 2, 0, 1);
        send_beat(4, 1, 0);
        send_beat(5, 0, 0);
        send_beat(9, 1, 0);
        send_beat(10, 0, 1);
        wait_drain();

        // Backpressure on the result while a new sop+eop beat waits upstream.
        stat_ready_i = 1'b0;
        push(2, 6, 14, 3, 2, 1, 0);
        send_beat(6, 1, 0);
        send_beat(6, 0, 0);
        send_beat(2, 0, 1);
        snk_data_i          = 8'd50;
        snk_startofpacket_i = 1'b1;
        snk_endofpacket_i   = 1'b1;
        snk_valid_i         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(stat_valid_o), 1);
            chk("stall_ready", 32'(snk_ready_o), 0);
            chk("stall_min", 32'(stat_min_o), 2);
            chk("stall_sum", 32'(stat_sum_o), 14);
            @(posedge clk_i); #1;
        end
        push(50, 50, 50, 1, 1, 0, 0);
        stat_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("post_hs_valid", 32'(stat_valid_o), 0);
        chk("post_hs_ready", 32'(snk_ready_o), 1);
        @(posedge clk_i); #1;
        snk_valid_i = 1'b0;
        chk("second_pkt_valid", 32'(stat_valid_o), 1);
        wait_drain();

        // Reset mid-packet, then reset while a result is pending.
        send_beat(77, 1, 0);
        send_beat(78, 0, 0);
        srst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        srst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_mid_no_result", 32'(stat_valid_o), 0);
        stat_ready_i = 1'b0;
        send_beat(99, 1, 1);
        chk("pending_valid", 32'(stat_valid_o), 1);
        srst_i = 1'b1;
        @(posedge clk_i); #1;
        srst_i = 1'b0;
        chk("rst_result_dropped", 32'(stat_valid_o), 0);
        chk("rst_result_ready", 32'(snk_ready_o), 1);
        stat_ready_i = 1'b1;

        push(10, 20, 65, 4, 3, 1, 0);
        send_beat(10, 1, 0);
        send_beat(20, 0, 0);
        send_beat(20, 0, 0);
        send_beat(15, 0, 1);
        wait_drain();
        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
